// File: rtl/topview_pkg.sv
// Shared constants and types for the topview segment reader and its output FIFO.
package topview_pkg;

  localparam int RAM_SIZE    = 4096;
  localparam int RAM_ADDR_W  = $clog2(RAM_SIZE);
  // Wide enough for any coordinate a 12-bit segment address space can describe.
  localparam int SEG_FIELD_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [SEG_FIELD_W-1:0] start_v;
    logic [SEG_FIELD_W-1:0] start_h;
    logic [SEG_FIELD_W-1:0] end_v;
    logic [SEG_FIELD_W-1:0] end_h;
  } seg_t;

  function automatic logic [RAM_ADDR_W-1:0] sat_inc(input logic [RAM_ADDR_W-1:0] val);
    return (&val) ? val : val + RAM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/topview_seg_fifo.sv
// Small synchronous segment FIFO with flush; occupancy is exposed so the reader
// can throttle address issue against entries already in flight.
module topview_seg_fifo
  import topview_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  seg_t             wr_data,
  input  logic             pop,
  input  logic             flush,
  output seg_t             rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  seg_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && !flush && (count != FULL_CNT);
  assign pop_ok  = pop && !flush && !empty;
  assign rd_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; a push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/topview_seg_reader.sv
// Topview segment reader: once the segment writer flags a complete frame, walks
// the segment BRAM in address order and streams valid entries out through a
// small FIFO with valid/ready handshake. Invalid entries are counted and dropped;
// losing tv_ready mid-frame aborts the frame and raises a sticky overrun flag.
//
// state    | meaning
// ST_IDLE  | waiting for a tv_ready rising edge with a non-zero line count
// ST_READ  | issuing BRAM addresses 0..N-1, throttled by FIFO space
// ST_DRAIN | all addresses issued; waiting for last read and FIFO to empty
// ST_DONE  | one-cycle frame_done pulse, then back to idle
module topview_seg_reader
  import topview_pkg::*;
#(
  parameter int  OUT_HEIGHT = 480,
  parameter int  OUT_WIDTH  = 640,
  parameter int  FIFO_DEPTH = 4,
  localparam int OUT_V_BITW = $clog2(OUT_HEIGHT),
  localparam int OUT_H_BITW = $clog2(OUT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tv_ready,
  input  logic [RAM_ADDR_W-1:0] tv_line_num,
  output logic [RAM_ADDR_W-1:0] raddr,
  input  logic [OUT_V_BITW-1:0] rd_start_v,
  input  logic [OUT_H_BITW-1:0] rd_start_h,
  input  logic [OUT_V_BITW-1:0] rd_end_v,
  input  logic [OUT_H_BITW-1:0] rd_end_h,
  input  logic                  rd_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_V_BITW-1:0] m_start_v,
  output logic [OUT_H_BITW-1:0] m_start_h,
  output logic [OUT_V_BITW-1:0] m_end_v,
  output logic [OUT_H_BITW-1:0] m_end_h,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [RAM_ADDR_W-1:0] drop_count
);

  localparam int             CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  rd_state_e             state;
  logic [RAM_ADDR_W-1:0] n_lines;
  logic                  tv_q;
  logic                  inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [CNT_W:0]        occ_sum;
  logic                  in_frame;
  logic                  abort;
  logic                  tv_rise;
  logic                  issue;
  logic                  last_addr;
  logic                  push;
  logic                  pop;
  logic                  drain_done;
  seg_t                  seg_in;
  seg_t                  seg_out;
  logic                  seg_bits_unused;

  assign in_frame  = (state == ST_READ) || (state == ST_DRAIN);
  assign abort     = in_frame && !tv_ready;
  assign tv_rise   = tv_ready && !tv_q;
  // Count the read in flight as occupied so its data always has a slot to land in.
  assign occ_sum   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = (state == ST_READ) && tv_ready && (occ_sum < DEPTH_V);
  assign last_addr = (raddr == n_lines - RAM_ADDR_W'(1));
  assign push      = inflight && rd_valid && !abort;
  assign pop       = m_valid && m_ready;
  // Look ahead one cycle so frame_done lands right after the final beat.
  assign drain_done = !inflight && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  assign seg_in = '{start_v: SEG_FIELD_W'(rd_start_v),
                    start_h: SEG_FIELD_W'(rd_start_h),
                    end_v:   SEG_FIELD_W'(rd_end_v),
                    end_h:   SEG_FIELD_W'(rd_end_h)};

  topview_seg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (seg_in),
    .pop     (pop),
    .flush   (abort),
    .rd_data (seg_out),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign m_valid   = !fifo_empty;
  assign m_start_v = seg_out.start_v[OUT_V_BITW-1:0];
  assign m_start_h = seg_out.start_h[OUT_H_BITW-1:0];
  assign m_end_v   = seg_out.end_v[OUT_V_BITW-1:0];
  assign m_end_h   = seg_out.end_h[OUT_H_BITW-1:0];
  // Upper field bits are always zero-extension padding.
  assign seg_bits_unused = ^seg_out;

  // Frame sequencing: edge detect, address issue, drain, completion and abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      raddr      <= '0;
      n_lines    <= '0;
      tv_q       <= 1'b0;
      inflight   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      tv_q       <= tv_ready;
      inflight   <= issue;
      frame_done <= 1'b0;
      if (in_frame && inflight && !rd_valid && !abort) drop_count <= sat_inc(drop_count);
      if (abort) begin
        state   <= ST_IDLE;
        raddr   <= '0;
        busy    <= 1'b0;
        overrun <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (tv_rise && (tv_line_num != '0)) begin
              n_lines    <= tv_line_num;
              raddr      <= '0;
              drop_count <= '0;
              overrun    <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_READ;
            end
          end
          ST_READ: begin
            if (issue) begin
              if (last_addr) state <= ST_DRAIN;
              else           raddr <= raddr + RAM_ADDR_W'(1);
            end
          end
          ST_DRAIN: begin
            if (drain_done) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            raddr <= '0;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
